dac_fifo: RTL and testbench
===========================

DAC_FIFO -- requirements
Module: dac_fifo

Interface
REQ-001 Parameter AW, default 4, log2 of FIFO depth; depth D = 2^AW stereo entries.
REQ-002 Parameter LOW_MARK, default 8, level below which refill request is raised.
REQ-003 clk  input  1  system clock (50 MHz), all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 wr_en  input  1  producer write strobe, one entry per cycle high.
REQ-006 wr_l  input  24  left sample to write, two's complement.
REQ-007 wr_r  input  24  right sample to write, two's complement.
REQ-008 next  input  1  DAC request pulse, one cycle high, advance to next sample.
REQ-009 sample_l  output  24  left sample currently presented to DAC, registered.
REQ-010 sample_r  output  24  right sample currently presented to DAC, registered.
REQ-011 full  output  1  FIFO holds D entries.
REQ-012 empty  output  1  FIFO holds 0 entries.
REQ-013 level  output  AW+1  current number of stored entries, 0..D.
REQ-014 low  output  1  refill request, level < LOW_MARK.
REQ-015 underrun  output  1  sticky flag, DAC requested while FIFO empty.
REQ-016 overflow  output  1  sticky flag, write attempted while full.
REQ-017 clr_flags  input  1  one-cycle pulse clearing underrun and overflow.

Function
REQ-018 Storage SHALL be D x 48-bit circular buffer, write pointer and read pointer AW bits each, wrapping D-1 -> 0 without gaps.
REQ-019 Count SHALL be tracked in separate AW+1-bit counter; full = (count == D), empty = (count == 0), level = count, all registered-state derived, no combinational path from inputs.
REQ-020 Write: wr_en high and full low at edge -> entry {wr_l, wr_r} stored at write pointer, pointer +1, count +1.
REQ-021 Write with full high SHALL be discarded, pointer/count unchanged, overflow set at same edge; a simultaneous next does not make room for it.
REQ-022 Pop: next high and empty low at edge -> sample_l/sample_r loaded from head entry, read pointer +1, count -1; new sample visible cycle after next (latency 1).
REQ-023 next high with empty high -> sample_l/sample_r loaded with 0 (silence), underrun set, pointers/count unchanged.
REQ-024 Simultaneous accepted write and pop SHALL leave count unchanged, both pointers advance.
REQ-025 Simultaneous write and next while empty: write accepted (count 0 -> 1), output loaded 0, underrun set; written entry delivered on following next.
REQ-026 sample_l/sample_r SHALL hold value between next pulses; only next changes them.
REQ-027 Sticky flags: set has priority over clr_flags in same cycle; otherwise clr_flags -> both 0 next cycle.
REQ-028 next held high several cycles SHALL pop once per cycle (no edge detection); DAC guarantees single-cycle pulses.
REQ-029 Block SHALL contain no state machine beyond pointers/count/flags/output register; single clock domain, no combinational loops.

Reset
REQ-030 rst_n low SHALL immediately force: pointers 0, count 0, sample_l = sample_r = 0, underrun = overflow = 0; hence empty = 1, full = 0, level = 0, low = 1 (LOW_MARK > 0).
REQ-031 Storage array contents SHALL not be reset; FIFO contents are void after reset.
REQ-032 Reset asserted mid-operation (pending write or next) SHALL discard that operation; first accepted operation is at first rising edge with rst_n high.
REQ-033 Reset release is synchronized externally; block assumes rst_n deassertion meets recovery timing.

Verification
REQ-034 After reset write 3 entries (L=0x0FF0F6,R=0xAA55A6; L=1,R=2; L=3,R=4), then 3 next pulses -> outputs 0x0FF0F6/0xAA55A6, 1/2, 3/4 each one cycle after pulse; level 3 -> 0, empty = 1.
REQ-035 Write 16 entries (AW=4) then a 17th -> full = 1, level = 16, overflow = 1, 17th value never appears at outputs; clr_flags -> overflow = 0.
REQ-036 next on empty FIFO holding prior output 0x123456 -> outputs become 0, underrun = 1, level stays 0.
REQ-037 FIFO at level 16, wr_en and next same cycle -> write rejected, overflow = 1, level 15; at level 5 same stimulus -> level 5, both pointers advance.
REQ-038 Fill/drain 40 entries with incrementing data through wrap-around -> outputs strictly in write order, low toggles at level 8 boundary.
REQ-039 Assert rst_n low mid-stream with level 7 -> level 0, outputs 0, flags 0 without waiting for clock edge.

Source files
------------

// File: rtl/dac_fifo.sv
// rtl/dac_fifo.sv - stereo 24-bit sample FIFO feeding a DAC, with refill and sticky error flags
// The presented sample is registered and changes only on a next pulse.
module dac_fifo #(
   parameter int AW       = 4,
   parameter int LOW_MARK = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [23:0]   wr_l,
   input  logic [23:0]   wr_r,
   input  logic          next,
   input  logic          clr_flags,
   output logic [23:0]   sample_l,
   output logic [23:0]   sample_r,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          low,
   output logic          underrun,
   output logic          overflow
);

   localparam int          D        = 1 << AW;
   localparam logic [AW:0] DEPTH_C  = D[AW:0];
   localparam logic [AW:0] LOW_C    = LOW_MARK[AW:0];

   logic [47:0]   mem_q [D];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [47:0]   sample_q, sample_d;
   logic          underrun_q, underrun_d;
   logic          overflow_q, overflow_d;
   logic          full_w, empty_w, wr_ok, rd_ok;

   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);
   // Fullness is judged before the edge, so a same-cycle pop never makes room for the write.
   assign wr_ok   = wr_en & ~full_w;
   assign rd_ok   = next & ~empty_w;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      sample_d   = sample_q;
      underrun_d = underrun_q;
      overflow_d = overflow_q;

      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (next) sample_d = empty_w ? 48'd0 : mem_q[rd_ptr_q];

      if (clr_flags) begin
         underrun_d = 1'b0;
         overflow_d = 1'b0;
      end
      if (next && empty_w)  underrun_d = 1'b1;
      if (wr_en && full_w)  overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         sample_q   <= '0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         sample_q   <= sample_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately left out of reset; its contents are meaningless once pointers clear.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= {wr_l, wr_r};
   end

   assign sample_l = sample_q[47:24];
   assign sample_r = sample_q[23:0];
   assign full     = full_w;
   assign empty    = empty_w;
   assign level    = count_q;
   assign low      = (count_q < LOW_C);
   assign underrun = underrun_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_dac_fifo.sv
// tb/tb_dac_fifo.sv - self-checking bench for dac_fifo
module tb_dac_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0, next = 1'b0, clr_flags = 1'b0;
   logic [23:0] wr_l = '0, wr_r = '0;
   logic [23:0] sample_l, sample_r;
   logic        full, empty, low, underrun, overflow;
   logic [4:0]  level;

   int tests = 0, fails = 0;
   logic [47:0] mdl [$];
   logic [47:0] m_sample;
   logic        m_unf, m_ovf;

   typedef struct {
      logic        we;
      logic [23:0] l, r;
      logic        nx, clr;
      int          exp_level;
      logic [23:0] exp_l, exp_r;
   } vec_t;
   vec_t vecs [11];

   dac_fifo #(.AW(4), .LOW_MARK(8)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_l(wr_l), .wr_r(wr_r),
      .next(next), .clr_flags(clr_flags), .sample_l(sample_l), .sample_r(sample_r),
      .full(full), .empty(empty), .level(level), .low(low),
      .underrun(underrun), .overflow(overflow)
   );

   always #10 clk = ~clk;

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm);
      chk({nm, " sample"}, {sample_l, sample_r}, m_sample);
      chk({nm, " level"}, 48'(level), 48'(mdl.size()));
      chk({nm, " full"}, 48'(full), 48'(mdl.size() == 16));
      chk({nm, " empty"}, 48'(empty), 48'(mdl.size() == 0));
      chk({nm, " low"}, 48'(low), 48'(mdl.size() < 8));
      chk({nm, " underrun"}, 48'(underrun), 48'(m_unf));
      chk({nm, " overflow"}, 48'(overflow), 48'(m_ovf));
   endtask

   task automatic model_reset();
      mdl.delete();
      m_sample = '0;
      m_unf = 1'b0;
      m_ovf = 1'b0;
   endtask

   // One clock: drive, predict from pre-edge state, then compare after the edge.
   task automatic step(input logic we, input logic [23:0] l, input logic [23:0] r,
                       input logic nx, input logic clr, input string nm);
      logic pre_full, pre_empty;
      wr_en = we; wr_l = l; wr_r = r; next = nx; clr_flags = clr;
      pre_full  = (mdl.size() == 16);
      pre_empty = (mdl.size() == 0);
      @(posedge clk); #1;
      if (clr) begin m_unf = 1'b0; m_ovf = 1'b0; end
      if (nx) begin
         if (pre_empty) begin m_sample = '0; m_unf = 1'b1; end
         else m_sample = mdl.pop_front();
      end
      if (we) begin
         if (pre_full) m_ovf = 1'b1;
         else mdl.push_back({l, r});
      end
      wr_en = 1'b0; next = 1'b0; clr_flags = 1'b0;
      chk_all(nm);
   endtask

   initial begin
      int wi, cyc, toggles;
      logic prev_low, do_w, do_n;

      model_reset();
      #25;
      chk_all("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      vecs[0]  = '{1, 24'h0FF0F6, 24'hAA55A6, 0, 0, 1, 24'h0, 24'h0};
      vecs[1]  = '{1, 24'h000001, 24'h000002, 0, 0, 2, 24'h0, 24'h0};
      vecs[2]  = '{1, 24'h000003, 24'h000004, 0, 0, 3, 24'h0, 24'h0};
      vecs[3]  = '{0, 24'h0, 24'h0, 1, 0, 2, 24'h0FF0F6, 24'hAA55A6};
      vecs[4]  = '{0, 24'h0, 24'h0, 1, 0, 1, 24'h000001, 24'h000002};
      vecs[5]  = '{0, 24'h0, 24'h0, 1, 0, 0, 24'h000003, 24'h000004};
      vecs[6]  = '{1, 24'h123456, 24'h123456, 0, 0, 1, 24'h000003, 24'h000004};
      vecs[7]  = '{0, 24'h0, 24'h0, 1, 0, 0, 24'h123456, 24'h123456};
      vecs[8]  = '{0, 24'h0, 24'h0, 1, 0, 0, 24'h0, 24'h0};
      vecs[9]  = '{1, 24'h777777, 24'h888888, 1, 1, 1, 24'h0, 24'h0};
      vecs[10] = '{0, 24'h0, 24'h0, 1, 0, 0, 24'h777777, 24'h888888};
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].we, vecs[i].l, vecs[i].r, vecs[i].nx, vecs[i].clr, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl_level", i), 48'(level), 48'(vecs[i].exp_level));
         chk($sformatf("vec%0d tbl_sample", i), {sample_l, sample_r}, {vecs[i].exp_l, vecs[i].exp_r});
      end
      chk("underrun sticky", 48'(underrun), 48'd1);

      step(0, 0, 0, 0, 1, "clr");
      for (int i = 0; i < 16; i++) step(1, 24'(i + 16), 24'(i + 100), 0, 0, "fill");
      chk("full at 16", 48'({full, level}), 48'({1'b1, 5'd16}));
      step(1, 24'hDEADBE, 24'hDEADBE, 0, 0, "write17");
      chk("overflow set", 48'(overflow), 48'd1);
      step(0, 0, 0, 0, 1, "clr ovf");
      chk("overflow cleared", 48'(overflow), 48'd0);

      step(1, 24'hBADBAD, 24'hBADBAD, 1, 0, "full wr+next");
      chk("full wr+next level", 48'(level), 48'd15);
      while (mdl.size() > 5) step(0, 0, 0, 1, 0, "drain to 5");
      step(1, 24'h555555, 24'h666666, 1, 0, "lvl5 wr+next");
      chk("lvl5 wr+next level", 48'(level), 48'd5);
      while (mdl.size() > 0) step(0, 0, 0, 1, 0, "drain");
      step(0, 0, 0, 0, 1, "clr2");

      wi = 0; cyc = 0; toggles = 0; prev_low = low;
      while ((wi < 40 || mdl.size() > 0) && cyc < 1000) begin
         do_w = (wi < 40) && (mdl.size() < 16) && ($urandom_range(0, 2) != 0);
         do_n = (mdl.size() > 0) && ((wi == 40) || ($urandom_range(0, 2) == 0));
         step(do_w, 24'(wi), 24'h800000 + 24'(wi), do_n, 0, "stream");
         if (do_w) wi++;
         if (low != prev_low) toggles++;
         prev_low = low;
         cyc++;
      end
      chk("stream complete", 48'(wi == 40 && mdl.size() == 0), 48'd1);
      chk("low toggled", 48'(toggles >= 2), 48'd1);

      for (int i = 0; i < 7; i++) step(1, 24'(i), 24'(i), 0, 0, "pre-reset fill");
      step(1, 24'h111111, 24'h222222, 1, 0, "pre-reset sample");
      wr_en = 1'b1; next = 1'b1;
      rst_n = 1'b0;
      #2;
      model_reset();
      chk_all("async reset");
      @(posedge clk); #1;
      chk_all("held reset");
      wr_en = 1'b0; next = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      step(1, 24'h00ABCD, 24'h00DCBA, 0, 0, "post-reset write");
      step(0, 0, 0, 1, 0, "post-reset pop");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
